// File: rtl/writeback_stage_pkg.sv
// Shared CPU package for the writeback stage.
// Holds the default data/address widths, the retire counter width and the
// hardwired-zero register index R0.
package writeback_stage_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 4;
  localparam int CNT_W     = 16;
  localparam int R0        = 0;

endpackage

// File: rtl/writeback_stage_reg_file_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Entry R0 is hardwired to zero: it always reads 0 and writes to it are dropped.
module reg_file_2r1w
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Storage update: clear everything on reset, otherwise write any register but R0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ADDR_W'(R0))) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == ADDR_W'(R0)) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == ADDR_W'(R0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: one pipeline register between the memory stage and the
// register file, a retired-write counter and the decode-stage read ports.
// Optional macro WB_BYPASS_EN: read ports see the writeback register's result
// in the cycle before it lands in the register file (write-through bypass).
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] reg_addr_in,
  input  logic              write_enable_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_reg_addr,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] result_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              vld_p1;
  logic              commit;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;

  // ---- stage p1: writeback register (holds on stall, flush drops the write)
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      result_p1 <= '0;
    end else if (!stall) begin
      vld_p1    <= write_enable_in & ~flush;
      addr_p1   <= reg_addr_in;
      result_p1 <= result_in;
    end
  end

  // A write to R0 never counts as a committing write.
  assign wb_valid    = vld_p1 && (addr_p1 != ADDR_W'(R0));
  assign wb_reg_addr = addr_p1;
  assign commit      = wb_valid & ~stall;

  // ---- stage p2: register-file update and retire counting
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
    end else if (commit) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  reg_file_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .we      (commit),
    .waddr   (addr_p1),
    .wdata   (result_p1),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rf_data_a),
    .rdata_b (rf_data_b)
  );

`ifdef WB_BYPASS_EN
  // Read ports forward the pending result; wb_valid excludes R0 so R0 still reads 0.
  always_comb begin
    rd_data_a = rf_data_a;
    rd_data_b = rf_data_b;
    if (wb_valid && (rd_addr_a == addr_p1)) rd_data_a = result_p1;
    if (wb_valid && (rd_addr_b == addr_p1)) rd_data_b = result_p1;
  end
`else
  assign rd_data_a = rf_data_a;
  assign rd_data_b = rf_data_b;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a behavioural
// model: an array of register values, one pending write and a retire count.
module tb_writeback_stage;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] result_in;
  logic [AW-1:0] reg_addr_in;
  logic          write_enable_in;
  logic          stall;
  logic          flush;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          wb_valid;
  logic [AW-1:0] wb_reg_addr;
  logic [15:0]   retire_count;

  writeback_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .result_in       (result_in),
    .reg_addr_in     (reg_addr_in),
    .write_enable_in (write_enable_in),
    .stall           (stall),
    .flush           (flush),
    .rd_addr_a       (rd_addr_a),
    .rd_addr_b       (rd_addr_b),
    .rd_data_a       (rd_data_a),
    .rd_data_b       (rd_data_b),
    .wb_valid        (wb_valid),
    .wb_reg_addr     (wb_reg_addr),
    .retire_count    (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [DW-1:0] m_rf [16];
  logic          m_pwe;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;
  logic [15:0]   m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_valid();
    return m_pwe && (m_pa != 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (m_valid() && a == m_pa) return m_pd;
`endif
    return m_rf[a];
  endfunction

  task automatic model_edge(input logic [DW-1:0] d, input logic [AW-1:0] a,
                            input logic w, input logic s, input logic f, input logic r);
    if (r) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_pwe = 1'b0;
      m_pa  = '0;
      m_pd  = '0;
      m_cnt = '0;
    end else if (!s) begin
      if (m_valid()) begin
        m_rf[m_pa] = m_pd;
        m_cnt      = m_cnt + 16'd1;
      end
      m_pwe = w && !f;
      m_pa  = a;
      m_pd  = d;
    end
  endtask

  task automatic check_outputs();
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid()});
    if (m_valid()) chk("wb_reg_addr", {28'd0, wb_reg_addr}, {28'd0, m_pa});
    chk("retire_count", {16'd0, retire_count}, {16'd0, m_cnt});
    chk("rd_data_a", {16'd0, rd_data_a}, {16'd0, exp_rd(rd_addr_a)});
    chk("rd_data_b", {16'd0, rd_data_b}, {16'd0, exp_rd(rd_addr_b)});
    if (rd_addr_a == rd_addr_b)
      chk("same_addr", {16'd0, rd_data_a}, {16'd0, rd_data_b});
  endtask

  // One clock: apply inputs, optionally check, take the edge, update the model.
  task automatic cyc(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic w,
                     input logic s, input logic f, input logic [AW-1:0] ra,
                     input logic [AW-1:0] rb, input bit do_chk);
    result_in       = d;
    reg_addr_in     = a;
    write_enable_in = w;
    stall           = s;
    flush           = f;
    rd_addr_a       = ra;
    rd_addr_b       = rb;
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_edge(d, a, w, s, f, reset);
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    cyc('0, '0, 1'b0, 1'b0, 1'b0, ra, rb, 1'b1);
  endtask

  task automatic read_a(input logic [AW-1:0] ra, input string tag, input logic [DW-1:0] exp);
    rd_addr_a = ra;
    #1;
    chk(tag, {16'd0, rd_data_a}, {16'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    result_in = '0; reg_addr_in = '0; write_enable_in = 1'b0;
    stall = 1'b0; flush = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 16'hDEAD;
    m_pwe = 1'b0; m_pa = '0; m_pd = '0; m_cnt = 16'h5A5A;

    // Reset held two cycles
    cyc('0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) read_a(AW'(i), "reset_rd", '0);
    chk("reset_cnt", {16'd0, retire_count}, 32'd0);
    chk("reset_wbv", {31'd0, wb_valid}, 32'd0);
    chk("reset_wba", {28'd0, wb_reg_addr}, 32'd0);

    // Basic write to R2, bypass probed on port b while it is pending
    cyc(16'h0010, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1);
    chk("basic_wbv", {31'd0, wb_valid}, 32'd1);
    rd_addr_b = 4'd2;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_rd", {16'd0, rd_data_b}, 32'h0010);
`else
    chk("bypass_rd", {16'd0, rd_data_b}, 32'h0000);
`endif
    idle(4'd2, 4'd2);
    chk("basic_wbv_off", {31'd0, wb_valid}, 32'd0);
    read_a(4'd2, "basic_rd", 16'h0010);
    chk("basic_cnt", {16'd0, retire_count}, 32'd1);

    // Stall with R5 pending; new input and flush during stall are ignored
    cyc(16'h0055, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 4'd1, 1'b1);
    cyc(16'h0077, 4'd7, 1'b1, 1'b1, 1'b0, 4'd5, 4'd7, 1'b1);
    cyc(16'h0077, 4'd7, 1'b1, 1'b1, 1'b1, 4'd5, 4'd7, 1'b1);
    cyc(16'h0077, 4'd7, 1'b1, 1'b1, 1'b0, 4'd5, 4'd7, 1'b1);
    chk("stall_cnt", {16'd0, retire_count}, 32'd1);
    chk("stall_wbv", {31'd0, wb_valid}, 32'd1);
    idle(4'd5, 4'd7);
    read_a(4'd5, "stall_rel_rd", 16'h0055);
    chk("stall_rel_cnt", {16'd0, retire_count}, 32'd2);

    // Flush squashes a write to R6
    cyc(16'h0066, 4'd6, 1'b1, 1'b0, 1'b1, 4'd6, 4'd6, 1'b1);
    chk("flush_wbv", {31'd0, wb_valid}, 32'd0);
    idle(4'd6, 4'd6);
    idle(4'd6, 4'd6);
    read_a(4'd6, "flush_rd", 16'h0000);

    // R0 write is discarded and not counted
    cyc(16'hFFFF, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    chk("r0_wbv", {31'd0, wb_valid}, 32'd0);
    idle(4'd0, 4'd0);
    idle(4'd0, 4'd0);
    read_a(4'd0, "r0_rd", 16'h0000);
    chk("r0_cnt", {16'd0, retire_count}, 32'd2);

    // Reset beats a pending write
    cyc(16'h0044, 4'd4, 1'b1, 1'b0, 1'b0, 4'd4, 4'd2, 1'b1);
    reset = 1'b1;
    cyc(16'h0099, 4'd9, 1'b1, 1'b1, 1'b0, 4'd4, 4'd2, 1'b0);
    reset = 1'b0;
    idle(4'd4, 4'd2);
    read_a(4'd4, "rst_pend_rd", 16'h0000);
    chk("rst_pend_cnt", {16'd0, retire_count}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(DW'($urandom), AW'($urandom), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
          AW'($urandom), AW'($urandom), 1'b1);
    end
    stall = 1'b0;
    idle(4'd1, 4'd2);

    // Counter wrap: back-to-back writes until the count reaches 0xFFFF
    while (m_cnt != 16'hFFFE) begin
      cyc(DW'($urandom), AW'($urandom_range(1, 15)), 1'b1, 1'b0, 1'b0,
          4'd0, 4'd0, 1'b0);
    end
    idle(4'd3, 4'd3);
    chk("cnt_ffff", {16'd0, retire_count}, 32'h0000FFFF);
    cyc(16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1);
    idle(4'd3, 4'd3);
    chk("cnt_wrap", {16'd0, retire_count}, 32'h00000000);
    read_a(4'd3, "wrap_rd", 16'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
